// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, owner encoding
// and the default fetch starvation bound.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  localparam int STARVE_LIMIT_DEF = 4;

  function automatic logic is_word_aligned(input logic [1:0] lo_bits);
    return (lo_bits == 2'b00);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data ports, with the data-grant streak
// counter that forces a fetch grant once fetch has waited STARVE_LIMIT grants.
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_if_req,
  input  logic   i_ls_req,
  input  logic   i_take,
  output owner_t o_owner
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] r_streak;
  logic          w_starved;

  assign w_starved = (r_streak == SW'(STARVE_LIMIT));
  assign o_owner   = (i_ls_req && !(i_if_req && w_starved)) ? OWN_LS : OWN_IF;

  // Streak only grows while fetch is actually waiting behind a data grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_streak <= '0;
    end else if (i_take) begin
      if (o_owner == OWN_LS && i_if_req) begin
        if (!w_starved) r_streak <= r_streak + SW'(1);
      end else begin
        r_streak <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory
// port; one access in flight, IDLE -> ACCESS -> RESP.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a port holds req and its operands until its gnt pulse; the
  // matching rvalid pulse arrives later. mem_req is held until mem_ready.

  state_t      r_state;
  owner_t      r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_if_gnt;
  logic        r_ls_gnt;
  logic        r_if_rvalid;
  logic        r_ls_rvalid;
  logic        r_ls_err;
  logic [31:0] r_if_rdata;
  logic [31:0] r_ls_rdata;

  owner_t      w_owner;
  logic        w_take;

  assign w_take = (r_state == ST_IDLE) && (if_req || ls_req);

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .i_if_req (if_req),
    .i_ls_req (ls_req),
    .i_take   (w_take),
    .o_owner  (w_owner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_ls_rdata  <= '0;
    end else begin
      r_if_gnt    <= 1'b0;
      r_ls_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_ls_rvalid <= 1'b0;
      r_ls_err    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_take) begin
            r_owner <= w_owner;
            if (w_owner == OWN_LS) begin
              r_ls_gnt <= 1'b1;
              if (is_word_aligned(ls_addr[1:0])) begin
                r_we    <= ls_we;
                r_addr  <= ls_addr;
                r_wdata <= ls_wdata;
                r_state <= ST_ACCESS;
              end else begin
                // Misaligned: answer with an error, never touch memory.
                r_ls_rvalid <= 1'b1;
                r_ls_err    <= 1'b1;
                r_ls_rdata  <= '0;
                r_state     <= ST_RESP;
              end
            end else begin
              r_if_gnt <= 1'b1;
              r_we     <= 1'b0;
              r_addr   <= if_addr & 32'hFFFF_FFFC;
              r_wdata  <= '0;
              r_state  <= ST_ACCESS;
            end
          end
        end
        ST_ACCESS: begin
          if (mem_ready) begin
            r_state <= ST_RESP;
            if (r_owner == OWN_LS) begin
              r_ls_rvalid <= 1'b1;
              r_ls_rdata  <= r_we ? 32'h0 : mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= mem_rdata;
            end
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign ls_gnt    = r_ls_gnt;
  assign ls_rvalid = r_ls_rvalid;
  assign ls_rdata  = r_ls_rdata;
  assign ls_err    = r_ls_err;
  assign mem_req   = (r_state == ST_ACCESS);
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4; max consecutive data grants while fetch waits.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 if_req  in  1  fetch request; if_addr held stable until if_gnt.
REQ-005 if_addr  in  32  fetch word address; bits [1:0] ignored, forced to 0 on memory.
REQ-006 if_gnt  out  1  one-cycle pulse, fetch request accepted.
REQ-007 if_rvalid  out  1  one-cycle pulse, if_rdata valid.
REQ-008 if_rdata  out  32  fetched instruction word.
REQ-009 ls_req  in  1  load/store request; ls_we, ls_addr, ls_wdata stable until ls_gnt.
REQ-010 ls_we  in  1  1 = store, 0 = load.
REQ-011 ls_addr  in  32  data byte address; must be word aligned.
REQ-012 ls_wdata  in  32  store data.
REQ-013 ls_gnt  out  1  one-cycle pulse, data request accepted.
REQ-014 ls_rvalid  out  1  one-cycle pulse; load data valid or store complete.
REQ-015 ls_rdata  out  32  load data; 0 for stores and errors.
REQ-016 ls_err  out  1  qualifies ls_rvalid; misaligned access, no memory cycle issued.
REQ-017 mem_req  out  1  memory access request, held until mem_ready.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_addr  out  32  memory address (latched at grant).
REQ-020 mem_wdata  out  32  memory write data (latched at grant).
REQ-021 mem_rdata  in  32  memory read data, valid when mem_ready=1.
REQ-022 mem_ready  in  1  access completes in any cycle with mem_req=1 and mem_ready=1.
REQ-023 busy  out  1  1 whenever state is not IDLE.

Function
REQ-024 FSM states IDLE, ACCESS, RESP; registered state, Moore outputs except where stated.
REQ-025 IDLE: no request -> stay; else pick winner, latch owner/addr/we/wdata, go ACCESS with winner's gnt=1 for exactly the first ACCESS cycle.
REQ-026 Pick: ls_req only -> data; if_req only -> fetch; both -> data unless streak == STARVE_LIMIT, then fetch.
REQ-027 Streak counter: +1 on data grant while if_req=1; cleared on fetch grant or data grant with if_req=0; saturates at STARVE_LIMIT.
REQ-028 Misaligned data request (ls_addr[1:0]!=0) as winner: IDLE -> RESP directly, ls_gnt=1, ls_rvalid=1, ls_err=1, ls_rdata=0 in that RESP cycle; mem_req stays 0; streak rules still apply.
REQ-029 ACCESS: mem_req=1, mem_we/addr/wdata from latches (mem_we=0 for fetch); on mem_ready=1 capture mem_rdata into owner's rdata register (0 for stores), go RESP; else stay, indefinitely.
REQ-030 RESP: owner's rvalid=1 for one cycle, then IDLE; minimum latency req-to-rvalid 2 cycles, throughput 1 access per 3 cycles.
REQ-031 Request deasserted before grant: discarded, no side effects; mem_ready while mem_req=0 ignored.
REQ-032 Non-owner gnt/rvalid/err always 0; rdata outputs hold last captured value.

Reset
REQ-033 reset low: immediately state=IDLE, streak=0, all outputs 0 (incl. mem_req, rdata); in-flight access abandoned, no rvalid issued after release.

Structure
REQ-034 Shared package: FSM state encoding, STARVE_LIMIT default, owner encoding (OWN_IF, OWN_LS).
REQ-035 One sub-module, mem_arb_pick: winner selection plus streak counter; remainder in top.

Verification
REQ-036 ls_req load 0x100, mem_ready=1 first ACCESS cycle, mem_rdata=0xDEADBEEF -> ls_gnt cycle 1, ls_rvalid cycle 2, ls_rdata=0xDEADBEEF.
REQ-037 if_req and ls_req both held continuously, STARVE_LIMIT=4 -> grant order LS,LS,LS,LS,IF,LS,...
REQ-038 ls_req store addr 0x102 -> ls_gnt=ls_rvalid=ls_err=1 same cycle, mem_req never asserted.
REQ-039 Fetch 0x40 with mem_ready low 5 cycles -> mem_req/mem_addr=0x40 held 6 cycles, if_rvalid one cycle after mem_ready.
REQ-040 reset asserted mid-ACCESS -> mem_req falls asynchronously, no rvalid after release, next request served normally.
